nubus_cpu_arbiter: RTL and testbench

NUBUS_CPU_ARBITER -- requirements
Module: nubus_cpu_arbiter

---
 rtl/nubus_cpu_arbiter.sv | 152 +++++++++++++++
 tb/tb_nubus_cpu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nubus_cpu_arbiter.sv
// Arbitrates two requesters onto the single NuBus master cpu port.
// Selection is round-robin, locked sequences are honoured, and BUSY is bounded by a watchdog.
module nubus_cpu_arbiter #(
    parameter int unsigned TIMEOUT_CLOCKS = 255
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,
    input  logic        r0_valid,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_wstrb,
    input  logic        r0_lock,
    output logic        r0_ready,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_valid,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_wstrb,
    input  logic        r1_lock,
    output logic        r1_ready,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic        cpu_valid,
    output logic [31:0] cpu_addr,
    output logic [31:0] cpu_wdata,
    output logic [3:0]  cpu_wstrb,
    output logic        cpu_lock,
    input  logic        cpu_ready,
    input  logic [31:0] cpu_rdata,
    output logic [1:0]  grant
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CLOCKS - 1);

    state_t      state_reg, state_next;
    logic [15:0] wd_reg;
    logic        locked_reg;
    logic        last_reg;
    logic [1:0]  grant_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        lock_reg;

    logic elig0, elig1, pick1, req_any, complete, timeout;

    // last_reg doubles as the lock owner: only the last grantee may hold the bus.
    always_comb begin
        elig0    = r0_valid && (!locked_reg || !last_reg);
        elig1    = r1_valid && (!locked_reg ||  last_reg);
        pick1    = elig1 && (!elig0 || !last_reg);
        req_any  = elig0 || elig1;
        complete = (state_reg == BUSY) && cpu_ready;
        timeout  = (state_reg == BUSY) && !cpu_ready && (wd_reg == WD_LAST);
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) state_reg <= IDLE;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_any) state_next = BUSY;
            BUSY:    if (complete || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            wd_reg     <= '0;
            locked_reg <= 1'b0;
            last_reg   <= 1'b1;
            grant_reg  <= 2'b00;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            lock_reg   <= 1'b0;
            r0_ready   <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= '0;
            r1_ready   <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= '0;
        end else begin
            r0_ready <= 1'b0;
            r0_err   <= 1'b0;
            r1_ready <= 1'b0;
            r1_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_any) begin
                        grant_reg <= pick1 ? 2'b10 : 2'b01;
                        last_reg  <= pick1;
                        addr_reg  <= pick1 ? r1_addr  : r0_addr;
                        wdata_reg <= pick1 ? r1_wdata : r0_wdata;
                        wstrb_reg <= pick1 ? r1_wstrb : r0_wstrb;
                        lock_reg  <= pick1 ? r1_lock  : r0_lock;
                        wd_reg    <= '0;
                    end
                end
                BUSY: begin
                    if (cpu_ready) begin
                        if (grant_reg[1]) begin
                            r1_ready <= 1'b1;
                            r1_rdata <= cpu_rdata;
                        end else begin
                            r0_ready <= 1'b1;
                            r0_rdata <= cpu_rdata;
                        end
                        locked_reg <= lock_reg;
                    end else if (wd_reg == WD_LAST) begin
                        if (grant_reg[1]) begin
                            r1_ready <= 1'b1;
                            r1_err   <= 1'b1;
                            r1_rdata <= 32'hFFFF_FFFF;
                        end else begin
                            r0_ready <= 1'b1;
                            r0_err   <= 1'b1;
                            r0_rdata <= 32'hFFFF_FFFF;
                        end
                        locked_reg <= 1'b0;
                        lock_reg   <= 1'b0;
                    end else begin
                        wd_reg <= wd_reg + 16'd1;
                    end
                end
                DONE: begin
                    // A held lock keeps ownership visible on the bus between transactions.
                    if (!locked_reg) begin
                        grant_reg <= 2'b00;
                        lock_reg  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_valid = (state_reg == BUSY);
        cpu_addr  = addr_reg;
        cpu_wdata = wdata_reg;
        cpu_wstrb = wstrb_reg;
        cpu_lock  = lock_reg;
        grant     = grant_reg;
    end
endmodule

// File: tb/tb_nubus_cpu_arbiter.sv
// Bench for nubus_cpu_arbiter: directed vector table, tie/lock/reset sequences and
// random traffic, all checked every cycle against a transaction-timeline reference.
module tb_nubus_cpu_arbiter;
    localparam int T = 8;

    logic        nub_clkn = 1'b0;
    logic        nub_resetn;
    logic        r0_valid, r1_valid, r0_lock, r1_lock;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [3:0]  r0_wstrb, r1_wstrb;
    logic        r0_ready, r1_ready, r0_err, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        cpu_valid, cpu_lock, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic [1:0]  grant;

    int total = 0;
    int bad = 0;

    nubus_cpu_arbiter #(.TIMEOUT_CLOCKS(T)) dut (
        .nub_clkn(nub_clkn), .nub_resetn(nub_resetn),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
        .r0_lock(r0_lock), .r0_ready(r0_ready), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
        .r1_lock(r1_lock), .r1_ready(r1_ready), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_lock(cpu_lock), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .grant(grant)
    );

    always #5 nub_clkn = ~nub_clkn;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference timeline model + memory slave ----------------
    logic [31:0] mem [16];
    bit          random_mode = 0;
    int          slave_wait = 0;
    int          m_cyc = 0, m_start = 0, m_end = 0, m_w = 0, m_free_at = 0;
    bit          m_serving = 0, m_owner = 0, m_last = 1, m_locked = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    bit          m_lock = 0;
    logic [1:0]  e_grant = 2'b00;
    bit          e_cpu_lock = 0;
    logic [31:0] e_rdata0 = '0, e_rdata1 = '0;
    bit          rdy0, rdy1, er0, er1, el0, el1, win, terr;
    int          lat_m;

    always @(negedge nub_clkn) begin
        m_cyc++;
        rdy0 = 0; rdy1 = 0; er0 = 0; er1 = 0;
        if (!nub_resetn) begin
            m_serving = 0; m_last = 1; m_locked = 0; m_free_at = 0;
            m_addr = '0; m_wdata = '0; m_wstrb = '0; m_lock = 0;
            e_grant = 2'b00; e_cpu_lock = 0; e_rdata0 = '0; e_rdata1 = '0;
        end else if (m_serving && m_cyc == m_end) begin
            terr = (m_w + 1 > T);
            if (m_owner) begin
                rdy1 = 1; er1 = terr;
                e_rdata1 = terr ? 32'hFFFF_FFFF : mem[m_addr[5:2]];
            end else begin
                rdy0 = 1; er0 = terr;
                e_rdata0 = terr ? 32'hFFFF_FFFF : mem[m_addr[5:2]];
            end
            if (terr) begin
                m_locked = 0;
                e_cpu_lock = 0;
            end else begin
                m_locked = m_lock;
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
            end
            m_serving = 0;
            m_free_at = m_cyc + 2;
        end else if (!m_serving && m_cyc == m_free_at - 1) begin
            if (!m_locked) begin
                e_grant = 2'b00;
                e_cpu_lock = 0;
            end
        end else if (!m_serving && m_cyc >= m_free_at) begin
            el0 = r0_valid && (!m_locked || !m_last);
            el1 = r1_valid && (!m_locked ||  m_last);
            if (el0 || el1) begin
                win = (el0 && el1) ? !m_last : el1;
                m_last = win; m_owner = win; m_serving = 1; m_start = m_cyc;
                m_w = random_mode ? int'($urandom_range(0, 10)) : slave_wait;
                lat_m = (m_w + 1 < T) ? m_w + 1 : T;
                m_end = m_cyc + lat_m;
                m_addr  = win ? r1_addr  : r0_addr;
                m_wdata = win ? r1_wdata : r0_wdata;
                m_wstrb = win ? r1_wstrb : r0_wstrb;
                m_lock  = win ? r1_lock  : r0_lock;
                e_grant = win ? 2'b10 : 2'b01;
                e_cpu_lock = m_lock;
            end
        end
        check($sformatf("cycle%0d", m_cyc),
              {cpu_valid, cpu_lock, grant, r0_ready, r0_err, r1_ready, r1_err,
               cpu_wstrb, cpu_addr, cpu_wdata, r0_rdata, r1_rdata},
              {m_serving, e_cpu_lock, e_grant, rdy0, er0, rdy1, er1,
               m_wstrb, m_addr, m_wdata, e_rdata0, e_rdata1});
        // slave: ready on the edge m_w+1 clocks after the grant edge; junk ready while idle
        if (nub_resetn && m_serving && (m_cyc + 1 == m_start + m_w + 1)) begin
            cpu_ready = 1'b1;
            cpu_rdata = mem[m_addr[5:2]];
        end else if (random_mode && !m_serving) begin
            cpu_ready = 1'($urandom_range(0, 1));
            cpu_rdata = $urandom;
        end else begin
            cpu_ready = 1'b0;
            cpu_rdata = $urandom;
        end
    end

    // ---------------- requester driving ----------------
    task automatic drive(input int n, input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit lk);
        if (n == 0) begin
            r0_valid = v; r0_addr = a; r0_wdata = d; r0_wstrb = s; r0_lock = lk;
        end else begin
            r1_valid = v; r1_addr = a; r1_wdata = d; r1_wstrb = s; r1_lock = lk;
        end
    endtask

    task automatic req(input int n, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit lk,
                       output int lat, output bit er, output logic [31:0] rd,
                       output bit v1, output logic [1:0] g1);
        bit got = 0;
        lat = -1; er = 0; rd = '0; v1 = 0; g1 = 2'b00;
        @(negedge nub_clkn); #1;
        drive(n, 1, a, d, s, lk);
        for (int k = 1; k <= 3000 && !got; k++) begin
            @(negedge nub_clkn);
            if (k == 1) begin v1 = cpu_valid; g1 = grant; end
            if ((n == 0) ? r0_ready : r1_ready) begin
                got = 1;
                lat = k - 1;
                er = (n == 0) ? r0_err : r1_err;
                rd = (n == 0) ? r0_rdata : r1_rdata;
            end
        end
        #1;
        drive(n, 0, a, d, s, lk);
        check($sformatf("ready_seen_r%0d", n), got, 1'b1);
        $display("txn r%0d addr=%h wstrb=%b lock=%0d lat=%0d err=%0d rdata=%h", n, a, s, lk, lat, er, rd);
    endtask

    task automatic rand_agent(input int n, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int lat;
            bit er, v1, lk;
            logic [31:0] rd;
            logic [1:0] g1;
            logic [3:0] s;
            repeat ($urandom_range(0, 3)) @(negedge nub_clkn);
            s  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            lk = (i != cnt - 1) && ($urandom_range(0, 3) == 0);
            req(n, 32'hF000_0000 | (32'($urandom_range(0, 15)) << 2), $urandom, s, lk, lat, er, rd, v1, g1);
        end
    endtask

    int order[$];
    function automatic int seq_code();
        int c = 0;
        foreach (order[i]) c = c * 4 + order[i] + 1;
        return c;
    endfunction

    typedef struct {
        bit          id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          lock;
        int          wait_clk;
        int          lat;
        bit          err;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        int lat, lat1, lat2;
        bit er, er1, er2, v1, v1b, v1c;
        logic [31:0] rd, rd1, rd2;
        logic [1:0] g1, g1b, g1c;

        vecs[0] = '{0, 32'hF000_0000, 32'h8765_4321, 4'b1111, 0, 5,  6, 0, 32'hC0DE_0000};
        vecs[1] = '{1, 32'hF000_0000, 32'h0,         4'b0000, 0, 0,  1, 0, 32'h8765_4321};
        vecs[2] = '{0, 32'hF000_0004, 32'h0,         4'b0000, 0, 7,  8, 0, 32'hC0DE_0001};
        vecs[3] = '{0, 32'hF000_0008, 32'h0,         4'b0000, 0, 8,  8, 1, 32'hFFFF_FFFF};
        vecs[4] = '{1, 32'hF000_000C, 32'h1122_3344, 4'b0011, 0, 2,  3, 0, 32'hC0DE_0003};
        vecs[5] = '{1, 32'hF000_000C, 32'h0,         4'b0000, 0, 1,  2, 0, 32'hC0DE_3344};
        vecs[6] = '{0, 32'hF000_0010, 32'h0,         4'b0000, 1, 30, 8, 1, 32'hFFFF_FFFF};

        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        drive(0, 0, '0, '0, '0, 0);
        drive(1, 0, '0, '0, '0, 0);
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        nub_resetn = 1'b0;
        repeat (3) @(negedge nub_clkn);
        check("reset_state", {cpu_valid, cpu_lock, grant, r0_ready, r0_err, r1_ready, r1_err,
                              cpu_wstrb, cpu_addr, cpu_wdata, r0_rdata, r1_rdata}, '0);
        #1 nub_resetn = 1'b1;

        // simultaneous requests straight after reset, r0 re-requests once
        slave_wait = 2;
        order.delete();
        fork
            begin
                req(0, 32'hF000_0018, '0, 4'h0, 0, lat1, er1, rd1, v1b, g1b);
                order.push_back(0);
                check("tie_r0a_rdata", rd1, 32'hC0DE_0006);
                req(0, 32'hF000_0020, '0, 4'h0, 0, lat1, er1, rd1, v1b, g1b);
                order.push_back(0);
                check("tie_r0b_rdata", rd1, 32'hC0DE_0008);
            end
            begin
                req(1, 32'hF000_001C, '0, 4'h0, 0, lat2, er2, rd2, v1c, g1c);
                order.push_back(1);
                check("tie_r1_rdata", rd2, 32'hC0DE_0007);
            end
        join
        check("tie_order", seq_code(), 25);

        // vector table: latency from request, error flag, returned data
        foreach (vecs[i]) begin
            slave_wait = vecs[i].wait_clk;
            req(int'(vecs[i].id), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].lock,
                lat, er, rd, v1, g1);
            check($sformatf("vec%0d_grant", i), {v1, g1}, {1'b1, vecs[i].id ? 2'b10 : 2'b01});
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_err", i), er, vecs[i].err);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end
        @(negedge nub_clkn);
        check("timeout_clears_lock", {cpu_valid, cpu_lock, grant}, 4'b0000);

        // r1 locked write, r0 waiting, then r1 unlocking read
        slave_wait = 3;
        order.delete();
        fork
            begin
                req(1, 32'hF000_0004, 32'hDEAD_BEEF, 4'hF, 1, lat1, er1, rd1, v1b, g1b);
                order.push_back(1);
                repeat (3) begin
                    @(negedge nub_clkn);
                    check("lock_gap", {cpu_valid, cpu_lock, grant}, 4'b0110);
                end
                req(1, 32'hF000_0004, '0, 4'h0, 0, lat1, er1, rd1, v1b, g1b);
                order.push_back(1);
                check("lock_r1_rdata", rd1, 32'hDEAD_BEEF);
            end
            begin
                repeat (2) @(negedge nub_clkn);
                req(0, 32'hF000_0008, '0, 4'h0, 0, lat2, er2, rd2, v1c, g1c);
                order.push_back(0);
            end
        join
        check("lock_order", seq_code(), 41);

        // reset in the middle of a BUSY transaction
        slave_wait = 30;
        @(negedge nub_clkn); #1;
        drive(0, 1, 32'hF000_0030, '0, 4'h0, 1);
        repeat (4) @(negedge nub_clkn);
        check("busy_before_reset", cpu_valid, 1'b1);
        #2 nub_resetn = 1'b0;
        #1 check("reset_async", {cpu_valid, cpu_lock, grant}, 4'b0000);
        repeat (3) begin
            @(negedge nub_clkn);
            check("reset_no_ready", {r0_ready, r1_ready}, 2'b00);
        end
        #1 drive(0, 0, '0, '0, '0, 0);
        @(negedge nub_clkn); #1 nub_resetn = 1'b1;
        slave_wait = 2;
        req(0, 32'hF000_0014, '0, 4'h0, 0, lat, er, rd, v1, g1);
        check("post_reset_lat", lat, 3);
        check("post_reset_resp", {er, rd}, {1'b0, 32'hC0DE_0005});

        // random traffic from both requesters
        random_mode = 1;
        fork
            rand_agent(0, 60);
            rand_agent(1, 60);
        join
        random_mode = 0;
        repeat (4) @(negedge nub_clkn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
